// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception controller.
package exc_pkg;

    typedef enum logic {
        IDLE,
        HANDLER
    } exc_state_e;

    localparam logic [3:0] ESR_INVOP   = 4'd1;
    localparam logic [3:0] ESR_IRQ     = 4'd2;
    localparam logic [3:0] ESR_BADERET = 4'd3;

    localparam int unsigned DOUBLE_FAULT_BIT = 63;

    localparam logic [1:0] MRS_ELR    = 2'b00;
    localparam logic [1:0] MRS_ESR    = 2'b01;
    localparam logic [1:0] MRS_STATUS = 2'b10;

endpackage

// File: rtl/exc_ctrl_if.sv
// Datapath-side bundle of the exception controller: event inputs, redirect strobes, sysregs.
interface exc_ctrl_if #(
    parameter int unsigned N = 64
);
    logic         ExtIRQ;
    logic         InvOp;
    logic         ERet;
    logic [N-1:0] PC;
    logic [1:0]   MrsSel;
    logic         Exc;
    logic [N-1:0] ExcVector;
    logic         ERetTaken;
    logic         Squash;
    logic [N-1:0] ELR;
    logic [N-1:0] ESR;
    logic         InHandler;
    logic         ExtIAck;
    logic [N-1:0] MrsData;

    modport master (
        output ExtIRQ, InvOp, ERet, PC, MrsSel,
        input  Exc, ExcVector, ERetTaken, Squash, ELR, ESR, InHandler, ExtIAck, MrsData
    );

    modport slave (
        input  ExtIRQ, InvOp, ERet, PC, MrsSel,
        output Exc, ExcVector, ERetTaken, Squash, ELR, ESR, InHandler, ExtIAck, MrsData
    );
endinterface

// File: rtl/exc_sysregs.sv
// ELR/ESR storage with load enables and the combinational MRS read mux.
module exc_sysregs
    import exc_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_elr_we,
    input  logic [N-1:0] i_elr_d,
    input  logic         i_esr_we,
    input  logic [N-1:0] i_esr_d,
    input  logic [1:0]   i_mrs_sel,
    input  logic         i_in_handler,
    output logic [N-1:0] o_elr,
    output logic [N-1:0] o_esr,
    output logic [N-1:0] o_mrs_data
);
    logic [N-1:0] r_elr;
    logic [N-1:0] r_esr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_elr <= '0;
            r_esr <= '0;
        end else begin
            if (i_elr_we) r_elr <= i_elr_d;
            if (i_esr_we) r_esr <= i_esr_d;
        end
    end

    // Reads see the pre-edge contents, so an MRS in a trapping cycle gets old values.
    always_comb begin
        o_mrs_data = '0;
        case (i_mrs_sel)
            MRS_ELR:    o_mrs_data = r_elr;
            MRS_ESR:    o_mrs_data = r_esr;
            MRS_STATUS: o_mrs_data = {{(N-1){1'b0}}, i_in_handler};
            default:    o_mrs_data = '0;
        endcase
    end

    assign o_elr = r_elr;
    assign o_esr = r_esr;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller for the single-cycle LEGv8 datapath: trap FSM and redirect strobes.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned N          = 64,
    parameter logic [N-1:0] EXC_VECTOR = 64'h00000000000000D8
) (
    input logic       clk,
    input logic       reset,
    exc_ctrl_if.slave bus
);
    exc_state_e   r_state;
    exc_state_e   w_state_next;
    logic         r_ext_iack;
    logic         w_iack_next;
    logic         w_exc;
    logic         w_eret_taken;
    logic         w_elr_we;
    logic         w_esr_we;
    logic [N-1:0] w_esr_d;
    logic [N-1:0] w_elr;
    logic [N-1:0] w_esr;
    logic [N-1:0] w_mrs_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ext_iack <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ext_iack <= w_iack_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_iack_next  = 1'b0;
        w_exc        = 1'b0;
        w_eret_taken = 1'b0;
        w_elr_we     = 1'b0;
        w_esr_we     = 1'b0;
        w_esr_d      = w_esr;
        case (r_state)
            IDLE: begin
                if (bus.InvOp) begin
                    w_exc        = 1'b1;
                    w_elr_we     = 1'b1;
                    w_esr_we     = 1'b1;
                    w_esr_d      = {{(N-4){1'b0}}, ESR_INVOP};
                    w_state_next = HANDLER;
                end else if (bus.ERet) begin
                    w_exc        = 1'b1;
                    w_elr_we     = 1'b1;
                    w_esr_we     = 1'b1;
                    w_esr_d      = {{(N-4){1'b0}}, ESR_BADERET};
                    w_state_next = HANDLER;
                end else if (bus.ExtIRQ) begin
                    w_exc        = 1'b1;
                    w_elr_we     = 1'b1;
                    w_esr_we     = 1'b1;
                    w_esr_d      = {{(N-4){1'b0}}, ESR_IRQ};
                    w_iack_next  = 1'b1;
                    w_state_next = HANDLER;
                end
            end
            HANDLER: begin
                // IRQs are masked here; only a fault or ERET can act.
                if (bus.InvOp) begin
                    w_exc                     = 1'b1;
                    w_esr_we                  = 1'b1;
                    w_esr_d[DOUBLE_FAULT_BIT] = 1'b1;
                end else if (bus.ERet) begin
                    w_eret_taken = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    exc_sysregs #(
        .N (N)
    ) u_sysregs (
        .clk          (clk),
        .reset        (reset),
        .i_elr_we     (w_elr_we),
        .i_elr_d      (bus.PC),
        .i_esr_we     (w_esr_we),
        .i_esr_d      (w_esr_d),
        .i_mrs_sel    (bus.MrsSel),
        .i_in_handler (r_state == HANDLER),
        .o_elr        (w_elr),
        .o_esr        (w_esr),
        .o_mrs_data   (w_mrs_data)
    );

    assign bus.Exc       = w_exc;
    assign bus.Squash    = w_exc;
    assign bus.ERetTaken = w_eret_taken;
    assign bus.ExcVector = EXC_VECTOR;
    assign bus.ELR       = w_elr;
    assign bus.ESR       = w_esr;
    assign bus.InHandler = (r_state == HANDLER);
    assign bus.ExtIAck   = r_ext_iack;
    assign bus.MrsData   = w_mrs_data;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    exc_ctrl_if #(.N(64)) bus ();

    exc_ctrl #(
        .N          (64),
        .EXC_VECTOR (64'h00000000000000D8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        reset      = 1'b1;
        bus.ExtIRQ = 1'b0;
        bus.InvOp  = 1'b0;
        bus.ERet   = 1'b0;
        bus.PC     = '0;
        bus.MrsSel = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        settle();

        // Reset / idle
        check("rst_exc", bus.Exc, 1'b0);
        check("rst_eret", bus.ERetTaken, 1'b0);
        check("rst_squash", bus.Squash, 1'b0);
        check("rst_elr", bus.ELR, 64'h0);
        check("rst_esr", bus.ESR, 64'h0);
        check("rst_inh", bus.InHandler, 1'b0);
        check("rst_iack", bus.ExtIAck, 1'b0);
        check("vector", bus.ExcVector, 64'hD8);

        // Undefined opcode, then ERET back
        bus.InvOp = 1'b1;
        bus.PC    = 64'h40;
        settle();
        check("invop_exc", bus.Exc, 1'b1);
        check("invop_squash", bus.Squash, 1'b1);
        check("invop_eret", bus.ERetTaken, 1'b0);
        tick();
        bus.InvOp = 1'b0;
        settle();
        check("invop_elr", bus.ELR, 64'h40);
        check("invop_esr", bus.ESR, 64'h1);
        check("invop_inh", bus.InHandler, 1'b1);
        check("invop_iack", bus.ExtIAck, 1'b0);
        bus.ERet = 1'b1;
        settle();
        check("eret_taken", bus.ERetTaken, 1'b1);
        check("eret_exc", bus.Exc, 1'b0);
        check("eret_squash", bus.Squash, 1'b0);
        tick();
        bus.ERet = 1'b0;
        settle();
        check("eret_inh", bus.InHandler, 1'b0);
        check("eret_elr", bus.ELR, 64'h40);

        // External IRQ held high
        bus.ExtIRQ = 1'b1;
        bus.PC     = 64'h100;
        settle();
        check("irq_exc", bus.Exc, 1'b1);
        check("irq_squash", bus.Squash, 1'b1);
        tick();
        settle();
        check("irq_esr", bus.ESR, 64'h2);
        check("irq_elr", bus.ELR, 64'h100);
        check("irq_iack1", bus.ExtIAck, 1'b1);
        check("irq_masked", bus.Exc, 1'b0);
        tick();
        settle();
        check("irq_iack2", bus.ExtIAck, 1'b0);
        check("irq_masked2", bus.Exc, 1'b0);
        bus.ExtIRQ = 1'b0;
        bus.ERet   = 1'b1;
        tick();
        bus.ERet = 1'b0;
        settle();
        check("irq_ret_inh", bus.InHandler, 1'b0);

        // InvOp beats IRQ; IRQ retaken right after ERET
        bus.InvOp  = 1'b1;
        bus.ExtIRQ = 1'b1;
        bus.PC     = 64'h20;
        tick();
        bus.InvOp = 1'b0;
        settle();
        check("prio_esr", bus.ESR, 64'h1);
        check("prio_elr", bus.ELR, 64'h20);
        check("prio_iack", bus.ExtIAck, 1'b0);
        bus.ERet = 1'b1;
        settle();
        check("prio_eret", bus.ERetTaken, 1'b1);
        tick();
        bus.ERet = 1'b0;
        settle();
        check("retake_exc", bus.Exc, 1'b1);
        check("retake_inh", bus.InHandler, 1'b0);
        tick();
        bus.ExtIRQ = 1'b0;
        settle();
        check("retake_esr", bus.ESR, 64'h2);
        check("retake_iack", bus.ExtIAck, 1'b1);

        // Double fault in handler, InvOp beats ERet
        bus.InvOp = 1'b1;
        bus.ERet  = 1'b1;
        bus.PC    = 64'h300;
        settle();
        check("dbl_exc", bus.Exc, 1'b1);
        check("dbl_eret", bus.ERetTaken, 1'b0);
        tick();
        bus.InvOp = 1'b0;
        bus.ERet  = 1'b0;
        settle();
        check("dbl_esr", bus.ESR, 64'h8000000000000002);
        check("dbl_elr", bus.ELR, 64'h20);
        check("dbl_inh", bus.InHandler, 1'b1);
        bus.MrsSel = 2'b00;
        settle();
        check("mrs_elr", bus.MrsData, 64'h20);
        bus.MrsSel = 2'b01;
        settle();
        check("mrs_esr", bus.MrsData, 64'h8000000000000002);
        bus.MrsSel = 2'b10;
        settle();
        check("mrs_stat1", bus.MrsData, 64'h1);
        bus.MrsSel = 2'b11;
        settle();
        check("mrs_rsvd", bus.MrsData, 64'h0);
        bus.ERet = 1'b1;
        tick();
        bus.ERet = 1'b0;

        // ERET outside handler is a fault
        bus.ERet   = 1'b1;
        bus.PC     = 64'h44;
        bus.MrsSel = 2'b10;
        settle();
        check("bad_exc", bus.Exc, 1'b1);
        check("bad_squash", bus.Squash, 1'b1);
        check("bad_eret", bus.ERetTaken, 1'b0);
        check("bad_mrs_pre", bus.MrsData, 64'h0);
        tick();
        bus.ERet = 1'b0;
        settle();
        check("bad_esr", bus.ESR, 64'h3);
        check("bad_elr", bus.ELR, 64'h44);
        check("bad_inh", bus.InHandler, 1'b1);

        // Reset mid-handler
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("mid_rst_inh", bus.InHandler, 1'b0);
        check("mid_rst_elr", bus.ELR, 64'h0);
        check("mid_rst_esr", bus.ESR, 64'h0);
        check("mid_rst_mrs", bus.MrsData, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
